// File: rtl/on_board.sv
// on_board: runs the pipelined 16-bit CPU system and shows general register gr[select_y] as 4 hex digits on a multiplexed 7-segment display.
// Latency: enable/start/select_y pass through SYNC_STAGES flops; seg/ga are registered one clock after scan_cnt/ydisp. A select_y change is visible after SYNC_STAGES+2 clocks.
// Backpressure: none, the display free-runs. Ports: clock, reset (async active-low), enable, start, select_y[2:0] in; seg[6:0] {a..g}, ga[3:0] (active-low, ga[0] rightmost) out.

module cpu_core (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [2:0]  select_y,
    input  logic [15:0] i_datain,
    input  logic [15:0] d_datain,
    output logic [7:0]  i_addr,
    output logic [15:0] d_addr,
    output logic [15:0] d_dataout,
    output logic        d_we,
    output logic [15:0] y
);
    // Instruction fields: op=[15:11] r1=[10:8] r2=[6:4] r3=[2:0] imm8=[7:0] imm4=[3:0]
    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_ADD   = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_ADDI  = 5'd3;
    localparam logic [4:0] OP_LDIH  = 5'd4;
    localparam logic [4:0] OP_LOAD  = 5'd5;
    localparam logic [4:0] OP_STORE = 5'd6;
    localparam logic [4:0] OP_JUMP  = 5'd7;

    logic [7:0]  pc, pc_d;
    logic [15:0] id_ir, id_ir_d, ex_ir, ex_ir_d, mem_ir, mem_ir_d, wb_ir, wb_ir_d;
    logic [15:0] reg_A, reg_A_d, reg_B, reg_B_d;
    logic [15:0] reg_C, reg_C_d, smdr, smdr_d, reg_C1, reg_C1_d;
    logic [15:0] gr   [0:7];
    logic [15:0] gr_d [0:7];
    logic        cf, cf_d;
    logic        run, wb_wr;
    logic [2:0]  a_idx, b_idx;
    logic        unused_ir_bits;

    function automatic logic writes_gr(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_ADDI, OP_LDIH, OP_LOAD};
    endfunction

    // The whole pipeline freezes unless both switches are on.
    assign run    = enable & start;
    assign wb_wr  = writes_gr(wb_ir[15:11]);
    assign y      = gr[select_y];
    assign i_addr = pc;
    assign d_addr = reg_C;
    assign d_dataout = smdr;
    assign d_we   = run & (mem_ir[15:11] == OP_STORE);
    assign unused_ir_bits = ^{ex_ir[10:8], mem_ir[10:0], wb_ir[7:0]};

    always_comb begin
        pc_d     = pc;
        id_ir_d  = id_ir;
        ex_ir_d  = ex_ir;
        mem_ir_d = mem_ir;
        wb_ir_d  = wb_ir;
        reg_A_d  = reg_A;
        reg_B_d  = reg_B;
        reg_C_d  = reg_C;
        smdr_d   = smdr;
        reg_C1_d = reg_C1;
        cf_d     = cf;
        gr_d     = gr;
        // Immediate ops use r1 as their source; stores carry r1 as data.
        a_idx = (id_ir[15:11] == OP_ADDI || id_ir[15:11] == OP_LDIH) ? id_ir[10:8] : id_ir[6:4];
        b_idx = (id_ir[15:11] == OP_STORE) ? id_ir[10:8] : id_ir[2:0];
        if (run) begin
            // IF
            pc_d    = pc + 8'd1;
            id_ir_d = i_datain;
            // ID: jumps resolve here, squashing the instruction fetched behind them
            if (id_ir[15:11] == OP_JUMP) begin
                pc_d    = id_ir[7:0];
                id_ir_d = {OP_NOP, 11'd0};
            end
            ex_ir_d = id_ir;
            // Write-through: a write-back in the same cycle is seen by decode.
            reg_A_d = (wb_wr && wb_ir[10:8] == a_idx) ? reg_C1 : gr[a_idx];
            reg_B_d = (wb_wr && wb_ir[10:8] == b_idx) ? reg_C1 : gr[b_idx];
            // EX
            mem_ir_d = ex_ir;
            smdr_d   = reg_B;
            case (ex_ir[15:11])
                OP_ADD:   {cf_d, reg_C_d} = {1'b0, reg_A} + {1'b0, reg_B};
                OP_SUB:   {cf_d, reg_C_d} = {1'b0, reg_A} - {1'b0, reg_B};
                OP_ADDI:  reg_C_d = reg_A + {8'h00, ex_ir[7:0]};
                OP_LDIH:  reg_C_d = reg_A + {ex_ir[7:0], 8'h00};
                OP_LOAD,
                OP_STORE: reg_C_d = reg_A + {12'h000, ex_ir[3:0]};
                default:  reg_C_d = 16'h0000;
            endcase
            // MEM
            wb_ir_d  = mem_ir;
            reg_C1_d = (mem_ir[15:11] == OP_LOAD) ? d_datain : reg_C;
            // WB
            if (wb_wr) gr_d[wb_ir[10:8]] = reg_C1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc     <= '0;
            id_ir  <= '0;
            ex_ir  <= '0;
            mem_ir <= '0;
            wb_ir  <= '0;
            reg_A  <= '0;
            reg_B  <= '0;
            reg_C  <= '0;
            smdr   <= '0;
            reg_C1 <= '0;
            cf     <= 1'b0;
            for (int i = 0; i < 8; i++) gr[i] <= '0;
        end else begin
            pc     <= pc_d;
            id_ir  <= id_ir_d;
            ex_ir  <= ex_ir_d;
            mem_ir <= mem_ir_d;
            wb_ir  <= wb_ir_d;
            reg_A  <= reg_A_d;
            reg_B  <= reg_B_d;
            reg_C  <= reg_C_d;
            smdr   <= smdr_d;
            reg_C1 <= reg_C1_d;
            cf     <= cf_d;
            for (int i = 0; i < 8; i++) gr[i] <= gr_d[i];
        end
    end
endmodule

module cpu_system (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [2:0]  select_y,
    output logic [15:0] y
);
    logic [7:0]  i_addr;
    logic [15:0] i_datain;
    logic [15:0] d_addr, d_dataout, d_datain;
    logic        d_we;
    logic [15:0] dmem [0:15];
    logic        unused_addr_bits;

    cpu_core C (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .select_y(select_y), .i_datain(i_datain), .d_datain(d_datain),
        .i_addr(i_addr), .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we), .y(y)
    );

    // Test program. Dependent instructions sit at least 3 slots apart
    // (no forwarding beyond the write-back write-through).
    always_comb begin
        case (i_addr)
            8'd0:    i_datain = 16'h2145; // LDIH gr1,0x45
            8'd1:    i_datain = 16'h2289; // LDIH gr2,0x89
            8'd2:    i_datain = 16'h23CD; // LDIH gr3,0xCD
            8'd3:    i_datain = 16'h1967; // ADDI gr1,0x67   -> 4567
            8'd4:    i_datain = 16'h1AAB; // ADDI gr2,0xAB   -> 89AB
            8'd5:    i_datain = 16'h1BEF; // ADDI gr3,0xEF   -> CDEF
            8'd6:    i_datain = 16'h0000; // NOP
            8'd7:    i_datain = 16'h0C12; // ADD  gr4,gr1,gr2 -> CF12
            8'd8:    i_datain = 16'h1531; // SUB  gr5,gr3,gr1 -> 8888
            8'd9:    i_datain = 16'h0E33; // ADD  gr6,gr3,gr3 -> 9BDE, cf=1
            8'd10:   i_datain = 16'h3403; // STORE gr4,[gr0+3]
            8'd11:   i_datain = 16'h2F03; // LOAD gr7,[gr0+3]
            8'd12:   i_datain = 16'h0000; // NOP
            8'd13:   i_datain = 16'h0000; // NOP
            8'd14:   i_datain = 16'h1F11; // ADDI gr7,0x11   -> CF23
            8'd15:   i_datain = 16'h380F; // JUMP 15 (park)
            default: i_datain = 16'h0000;
        endcase
    end

    always_ff @(posedge clock) begin
        if (d_we) dmem[d_addr[3:0]] <= d_dataout;
    end
    assign d_datain = dmem[d_addr[3:0]];
    assign unused_addr_bits = ^d_addr[15:4];
endmodule

module on_board #(
    parameter int SCAN_BITS   = 18,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       start,
    input  logic [2:0] select_y,
    output logic [6:0] seg,
    output logic [3:0] ga
);
    logic [SYNC_STAGES-1:0]      en_sync_q, en_sync_d;
    logic [SYNC_STAGES-1:0]      st_sync_q, st_sync_d;
    logic [SYNC_STAGES-1:0][2:0] sel_sync_q, sel_sync_d;
    logic                        enable_s, start_s;
    logic [2:0]                  select_s;
    logic [15:0]                 y;
    logic [SCAN_BITS-1:0]        scan_cnt_q, scan_cnt_d;
    logic [15:0]                 ydisp_q, ydisp_d;
    logic [6:0]                  seg_q, seg_d;
    logic [3:0]                  ga_q, ga_d;
    logic [1:0]                  digit;
    logic [3:0]                  nibble;

    assign enable_s = en_sync_q[SYNC_STAGES-1];
    assign start_s  = st_sync_q[SYNC_STAGES-1];
    assign select_s = sel_sync_q[SYNC_STAGES-1];

    cpu_system a (
        .clock(clock), .reset(reset), .enable(enable_s), .start(start_s),
        .select_y(select_s), .y(y)
    );

    always_comb begin
        en_sync_d     = en_sync_q;
        st_sync_d     = st_sync_q;
        sel_sync_d    = sel_sync_q;
        en_sync_d[0]  = enable;
        st_sync_d[0]  = start;
        sel_sync_d[0] = select_y;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            en_sync_d[i]  = en_sync_q[i-1];
            st_sync_d[i]  = st_sync_q[i-1];
            sel_sync_d[i] = sel_sync_q[i-1];
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_BITS'(1);
        ydisp_d    = y;
        digit      = scan_cnt_q[SCAN_BITS-1 -: 2];
        nibble     = ydisp_q[3:0];
        ga_d       = 4'b1110;
        case (digit)
            2'd0: begin nibble = ydisp_q[3:0];   ga_d = 4'b1110; end
            2'd1: begin nibble = ydisp_q[7:4];   ga_d = 4'b1101; end
            2'd2: begin nibble = ydisp_q[11:8];  ga_d = 4'b1011; end
            default: begin nibble = ydisp_q[15:12]; ga_d = 4'b0111; end
        endcase
        case (nibble)
            4'h0: seg_d = 7'b0000001;
            4'h1: seg_d = 7'b1001111;
            4'h2: seg_d = 7'b0010010;
            4'h3: seg_d = 7'b0000110;
            4'h4: seg_d = 7'b1001100;
            4'h5: seg_d = 7'b0100100;
            4'h6: seg_d = 7'b0100000;
            4'h7: seg_d = 7'b0001111;
            4'h8: seg_d = 7'b0000000;
            4'h9: seg_d = 7'b0000100;
            4'hA: seg_d = 7'b0001000;
            4'hB: seg_d = 7'b1100000;
            4'hC: seg_d = 7'b0110001;
            4'hD: seg_d = 7'b1000010;
            4'hE: seg_d = 7'b0110000;
            default: seg_d = 7'b0111000;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            en_sync_q  <= '0;
            st_sync_q  <= '0;
            sel_sync_q <= '0;
            scan_cnt_q <= '0;
            ydisp_q    <= '0;
            seg_q      <= 7'b1111111;
            ga_q       <= 4'b1111;
        end else begin
            en_sync_q  <= en_sync_d;
            st_sync_q  <= st_sync_d;
            sel_sync_q <= sel_sync_d;
            scan_cnt_q <= scan_cnt_d;
            ydisp_q    <= ydisp_d;
            seg_q      <= seg_d;
            ga_q       <= ga_d;
        end
    end

    assign seg = seg_q;
    assign ga  = ga_q;
endmodule

// File: tb/tb_on_board.sv
// tb_on_board: scoreboard bench for on_board with a short scan counter.
// Latency: expected display words are queued one clock before the edge that should produce them.
// Backpressure: none; all waits on the DUT are cycle-bounded.
module tb_on_board;
    localparam int SB = 4;
    localparam int SS = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       start = 1'b0;
    logic [2:0] select_y = 3'd0;
    logic [6:0] seg;
    logic [3:0] ga;

    on_board #(.SCAN_BITS(SB), .SYNC_STAGES(SS)) dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .select_y(select_y), .seg(seg), .ga(ga)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [6:0] hex_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Register contents once the test program has parked.
    logic [15:0] exp_gr [8] = '{16'h0000, 16'h4567, 16'h89AB, 16'hCDEF,
                                16'hCF12, 16'h8888, 16'h9BDE, 16'hCF23};

    // Reference refresh counter, restarted by reset.
    logic [SB-1:0] mcnt;
    always @(posedge clock or negedge reset) begin
        if (!reset) mcnt <= '0;
        else        mcnt <= mcnt + SB'(1);
    end

    logic [10:0] sb_q [$];

    function automatic logic [10:0] disp_model(input logic [SB-1:0] cnt, input logic [15:0] v);
        logic [1:0] d;
        logic [3:0] nib;
        logic [3:0] an;
        d = cnt[SB-1:SB-2];
        case (d)
            2'd0:    begin nib = v[3:0];   an = 4'b1110; end
            2'd1:    begin nib = v[7:4];   an = 4'b1101; end
            2'd2:    begin nib = v[11:8];  an = 4'b1011; end
            default: begin nib = v[15:12]; an = 4'b0111; end
        endcase
        return {an, hex_tab[nib]};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            #50;
            checks++;
            if (ga !== 4'b1111 || seg !== 7'b1111111 || dut.a.C.pc !== 8'd0) begin
                errors++;
                $display("FAIL reset_hold t=%0t: ga=%b seg=%b pc=%0d, expected ga=1111 seg=1111111 pc=0",
                         $time, ga, seg, dut.a.C.pc);
            end
        end
        reset = 1'b1;   // t=300, on a falling edge
        #10 enable = 1'b1;
        #6;             // two rising edges after release
        checks++;
        if (ga !== 4'b1110 || seg !== hex_tab[0]) begin
            errors++;
            $display("FAIL reset_release: ga=%b seg=%b, expected ga=1110 seg=%b", ga, seg, hex_tab[0]);
        end
        #4 start = 1'b1;
    endtask

    task automatic test_scan_order();
        logic [10:0] e;
        @(negedge clock);
        select_y = 3'd1;
        repeat (60) @(posedge clock);
        #1;
        checks++;
        if (dut.y !== exp_gr[1]) begin
            errors++;
            $display("FAIL scan_y: y=%h, expected %h", dut.y, exp_gr[1]);
        end
        @(negedge clock);
        for (int i = 0; i < 20; i++) begin
            sb_q.push_back(disp_model(mcnt, exp_gr[1]));
            @(posedge clock); #1;
            e = sb_q.pop_front();
            checks++;
            if ({ga, seg} !== e) begin
                errors++;
                $display("FAIL scan_order cycle %0d: ga=%b seg=%b, expected ga=%b seg=%b",
                         i, ga, seg, e[10:7], e[6:0]);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_register_select();
        logic [10:0] e;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            select_y = 3'(k);
            repeat (SS + 1) @(posedge clock);
            @(negedge clock);
            // First comparison lands on the (SS+2)th edge after the change.
            for (int i = 0; i < 16; i++) begin
                sb_q.push_back(disp_model(mcnt, exp_gr[k]));
                @(posedge clock); #1;
                e = sb_q.pop_front();
                checks++;
                if ({ga, seg} !== e) begin
                    errors++;
                    $display("FAIL select_gr%0d cycle %0d: ga=%b seg=%b, expected ga=%b seg=%b",
                             k, i, ga, seg, e[10:7], e[6:0]);
                end
                @(negedge clock);
            end
            checks++;
            if (dut.y !== exp_gr[k]) begin
                errors++;
                $display("FAIL select_y_gr%0d: y=%h, expected %h", k, dut.y, exp_gr[k]);
            end
            repeat (80) @(posedge clock);
        end
        #1;
        checks++;
        if (dut.a.C.cf !== 1'b1) begin
            errors++;
            $display("FAIL carry_flag: cf=%b, expected 1", dut.a.C.cf);
        end
    endtask

    task automatic test_mid_reset();
        logic [10:0] e;
        int guard;
        @(negedge clock);
        select_y = 3'd0;
        repeat (SS + 3) @(posedge clock);
        guard = 0;
        do begin
            @(posedge clock); #1;
            guard++;
        end while (ga !== 4'b1011 && guard < 64);
        checks++;
        if (ga !== 4'b1011) begin
            errors++;
            $display("FAIL mid_reset_wait: ga=%b after %0d cycles, expected 1011", ga, guard);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (ga !== 4'b1111 || seg !== 7'b1111111) begin
            errors++;
            $display("FAIL mid_reset_async: ga=%b seg=%b, expected ga=1111 seg=1111111", ga, seg);
        end
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (dut.a.C.pc !== 8'd0 || ga !== 4'b1111) begin
            errors++;
            $display("FAIL mid_reset_hold: pc=%0d ga=%b, expected pc=0 ga=1111", dut.a.C.pc, ga);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(disp_model(mcnt, 16'h0000));
            @(posedge clock); #1;
            e = sb_q.pop_front();
            checks++;
            if ({ga, seg} !== e) begin
                errors++;
                $display("FAIL mid_reset_restart cycle %0d: ga=%b seg=%b, expected ga=%b seg=%b",
                         i, ga, seg, e[10:7], e[6:0]);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_gating();
        logic [10:0] e;
        logic [7:0]  pc_held;
        repeat (60) @(posedge clock);
        @(negedge clock);
        select_y = 3'd7;
        repeat (SS + 1) @(posedge clock);
        @(negedge clock);
        enable = 1'b0;
        repeat (SS + 2) @(posedge clock);
        #1 pc_held = dut.a.C.pc;
        @(negedge clock);
        for (int i = 0; i < 12; i++) begin
            sb_q.push_back(disp_model(mcnt, exp_gr[7]));
            @(posedge clock); #1;
            e = sb_q.pop_front();
            checks++;
            if ({ga, seg} !== e || dut.a.C.pc !== pc_held) begin
                errors++;
                $display("FAIL gating_hold cycle %0d: ga=%b seg=%b pc=%0d, expected ga=%b seg=%b pc=%0d",
                         i, ga, seg, dut.a.C.pc, e[10:7], e[6:0], pc_held);
            end
            @(negedge clock);
        end
        // Restart from reset with the CPU disabled: nothing may execute.
        reset = 1'b0;
        select_y = 3'd1;
        #20 reset = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        checks++;
        if (dut.a.C.pc !== 8'd0 || dut.y !== 16'h0000) begin
            errors++;
            $display("FAIL gating_idle: pc=%0d y=%h, expected pc=0 y=0000", dut.a.C.pc, dut.y);
        end
        @(negedge clock);
        enable = 1'b1;
        repeat (60) @(posedge clock);
        #1;
        checks++;
        if (dut.y !== exp_gr[1]) begin
            errors++;
            $display("FAIL gating_resume: y=%h, expected %h", dut.y, exp_gr[1]);
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_register_select();
        test_mid_reset();
        test_gating();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
